// File: rtl/jtdsp16_pkg.sv
// Shared types and sizing for the jtdsp16 loop cache ("do K {NI}" / "redo K").
package jtdsp16_pkg;

   localparam int CACHE_DEPTH = 15;  // entries; entry index 15 is never used
   localparam int NI_W        = 4;   // loop body length / pointer width
   localparam int K_W         = 7;   // iteration count width
   localparam int INSTR_W     = 16;  // instruction word width

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_REPLAY = 2'd2
   } state_t;

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// 15x16 register file: one synchronous write port, one asynchronous read port.
module jtdsp16_cache_mem
   import jtdsp16_pkg::*;
(
   input  logic               clk,
   input  logic               i_we,
   input  logic [NI_W-1:0]    i_waddr,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic [NI_W-1:0]    i_raddr,
   output logic [INSTR_W-1:0] o_rdata
);

   localparam logic [NI_W-1:0] LAST_ADDR = NI_W'(CACHE_DEPTH - 1);

   logic [INSTR_W-1:0] r_mem [CACHE_DEPTH];

   // Write one instruction word; out-of-range addresses are dropped.
   // NOTE: the array has no reset on purpose -- contents are only ever read
   // after being written by a LOAD, and a reset would cost a mux per bit.
   always_ff @(posedge clk) begin
      if (i_we && (i_waddr <= LAST_ADDR))
         r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = (i_raddr <= LAST_ADDR) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/jtdsp16_cache.sv
// Loop cache for the DSP16 "do K {NI}" / "redo K" instructions: captures a
// loop body from ROM on its first pass, then replays it from local storage
// while holding the program counter.
module jtdsp16_cache
   import jtdsp16_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cen,
   input  logic               do_en,
   input  logic               redo_en,
   input  logic [NI_W-1:0]    ni,
   input  logic [K_W-1:0]     k,
   input  logic               fetch,
   input  logic [INSTR_W-1:0] rom_dout,
   output logic [INSTR_W-1:0] cache_dout,
   output logic               cache_sel,
   output logic               pc_hold,
   output logic               busy
);

   state_t             r_state;
   logic [NI_W-1:0]    r_ni;
   logic [K_W-1:0]     r_k;
   logic [NI_W-1:0]    r_wr_ptr;
   logic [NI_W-1:0]    r_rd_ptr;
   logic [K_W-1:0]     r_iter;
   logic               r_body_valid;
   logic [INSTR_W-1:0] r_dout_hold;

   logic               w_fetch;
   logic               w_we;
   logic               w_last_wr;
   logic               w_last_rd;
   logic [INSTR_W-1:0] w_rd_data;

   // A fetch paired with do/redo is the loop instruction itself, not body.
   assign w_fetch   = fetch & ~do_en & ~redo_en;
   assign w_we      = ~rst & cen & (r_state == ST_LOAD) & w_fetch;
   assign w_last_wr = (r_wr_ptr == r_ni - NI_W'(1));
   assign w_last_rd = (r_rd_ptr == r_ni - NI_W'(1));

   jtdsp16_cache_mem u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (rom_dout),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   // Loop sequencer: IDLE -> LOAD (first pass from ROM) -> REPLAY (K-1 passes).
   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_ni         <= '0;
         r_k          <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_iter       <= '0;
         r_body_valid <= 1'b0;
         r_dout_hold  <= '0;
      end else if (cen) begin
         unique case (r_state)
            ST_IDLE: begin
               if (do_en && (ni != '0) && (k != '0)) begin
                  r_ni         <= ni;
                  r_k          <= k;
                  r_wr_ptr     <= '0;
                  r_body_valid <= 1'b0;
                  r_state      <= ST_LOAD;
               end else if (redo_en && r_body_valid && (k != '0)) begin
                  r_iter   <= k;
                  r_rd_ptr <= '0;
                  r_state  <= ST_REPLAY;
               end
            end
            ST_LOAD: begin
               if (w_fetch) begin
                  if (w_last_wr) begin
                     // Park the pointer at 0 so it never reaches entry 15.
                     r_wr_ptr     <= '0;
                     r_body_valid <= 1'b1;
                     if (r_k == K_W'(1)) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_iter   <= r_k - K_W'(1);
                        r_rd_ptr <= '0;
                        r_state  <= ST_REPLAY;
                     end
                  end else begin
                     r_wr_ptr <= r_wr_ptr + NI_W'(1);
                  end
               end
            end
            ST_REPLAY: begin
               // Track the presented word so it persists after REPLAY ends.
               r_dout_hold <= w_rd_data;
               if (w_fetch) begin
                  if (w_last_rd) begin
                     r_rd_ptr <= '0;
                     r_iter   <= r_iter - K_W'(1);
                     if (r_iter == K_W'(1))
                        r_state <= ST_IDLE;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + NI_W'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cache_sel  = (r_state == ST_REPLAY);
   assign pc_hold    = (r_state == ST_REPLAY);
   assign busy       = (r_state != ST_IDLE);
   assign cache_dout = (r_state == ST_REPLAY) ? w_rd_data : r_dout_hold;

endmodule
